// File: rtl/seqdet_pkg.sv
// Shared types and defaults for the 1101 sequence-detector family
// and its bit serializer.
package seqdet_pkg;

  localparam int SER_DEFAULT_WIDTH = 8;
  localparam int SER_DEFAULT_GAP   = 0;
  localparam int SER_GAP_W         = 4;  // holds GAP-1 for GAP up to 15

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } ser_state_t;

  typedef enum logic [2:0] {
    DET_S0,
    DET_S1,
    DET_S11,
    DET_S110,
    DET_S1101
  } det_state_t;

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words on valid/ready and
// emits one bit per clock, with optional idle gap after each word.
module piso_bit_serializer #(
  parameter int WIDTH     = seqdet_pkg::SER_DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = seqdet_pkg::SER_DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_ready,
  output logic             o_data,
  output logic             o_bit_valid,
  output logic             o_last
);
  import seqdet_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // The GAP parameter shadows the enum member, so that state is scoped explicitly.
  ser_state_t             state_q, state_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SER_GAP_W-1:0]   gap_q, gap_d;

  logic last_bit;
  logic head_bit;
  logic accept;

  assign last_bit = (cnt_q == LAST_IDX);
  assign head_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign accept   = i_valid && o_ready;

  // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = i_word;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          cnt_d   = cnt_q + CW'(1);
          shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
        end else if (GAP > 0) begin
          state_d = seqdet_pkg::GAP;
          gap_d   = SER_GAP_W'(GAP - 1);
          cnt_d   = '0;
        end else if (accept) begin
          shreg_d = i_word;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      seqdet_pkg::GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - SER_GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; o_ready never looks at i_valid.
  always_comb begin
    o_ready     = 1'b0;
    o_data      = 1'b0;
    o_bit_valid = 1'b0;
    o_last      = 1'b0;
    case (state_q)
      IDLE:  o_ready = 1'b1;
      SHIFT: begin
        o_bit_valid = 1'b1;
        o_data      = head_bit;
        o_last      = last_bit;
        o_ready     = (GAP == 0) && last_bit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed self-checking bench for piso_bit_serializer: default config,
// LSB-first config and a GAP=2 config share one clock and reset.
module tb_piso_bit_serializer;

  logic clk = 1'b0;
  logic reset;

  logic       valid_a, valid_b, valid_c;
  logic [7:0] word_a, word_b, word_c;
  logic       ready_a, data_a, bv_a, last_a;
  logic       ready_b, data_b, bv_b, last_b;
  logic       ready_c, data_c, bv_c, last_c;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) u_a (
    .clk(clk), .reset(reset), .i_valid(valid_a), .i_word(word_a),
    .o_ready(ready_a), .o_data(data_a), .o_bit_valid(bv_a), .o_last(last_a)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) u_b (
    .clk(clk), .reset(reset), .i_valid(valid_b), .i_word(word_b),
    .o_ready(ready_b), .o_data(data_b), .o_bit_valid(bv_b), .o_last(last_b)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(2)) u_c (
    .clk(clk), .reset(reset), .i_valid(valid_c), .i_word(word_c),
    .o_ready(ready_c), .o_data(data_c), .o_bit_valid(bv_c), .o_last(last_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int inst, input logic ev,
                          input logic ed, input logic el, input logic er);
    logic v, d, l, r;
    case (inst)
      0:       begin v = bv_a; d = data_a; l = last_a; r = ready_a; end
      1:       begin v = bv_b; d = data_b; l = last_b; r = ready_b; end
      default: begin v = bv_c; d = data_c; l = last_c; r = ready_c; end
    endcase
    chk({tag, ".bit_valid"}, v, ev);
    chk({tag, ".data"},      d, ed);
    chk({tag, ".last"},      l, el);
    chk({tag, ".ready"},     r, er);
  endtask

  initial begin
    logic [7:0] w;
    logic [3:0] hist;
    int         hits;

    reset   = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    word_a  = '0;   word_b  = '0;   word_c  = '0;
    #2;
    chk_outs("reset_a", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("reset_b", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_outs("reset_c", 2, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    reset = 1'b0;
    step();

    // Single word 8'hD0, MSB first: 1,1,0,1,0,0,0,0 and one 1101 hit.
    w = 8'hD0; valid_a = 1'b1; word_a = w; hist = '0; hits = 0;
    step();
    for (int k = 1; k <= 8; k++) begin
      chk_outs($sformatf("d0[%0d]", k), 0, 1'b1, w[8-k], k == 8, k == 8);
      hist = {hist[2:0], data_a};
      if (hist == 4'b1101) hits++;
      if (k == 1) valid_a = 1'b0;
      step();
    end
    chk_outs("d0_idle", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    assert (hits == 1) else begin
      miscompares++;
      $error("FAIL d0_detect: observed %0d hits expected 1", hits);
    end

    // Back-to-back 8'hDD with valid held: 16 bits with no bubble.
    w = 8'hDD; valid_a = 1'b1; word_a = w;
    step();
    for (int k = 1; k <= 16; k++) begin
      chk_outs($sformatf("dd[%0d]", k), 0, 1'b1, w[7-((k-1)%8)], (k % 8) == 0, (k % 8) == 0);
      if (k == 16) valid_a = 1'b0;
      step();
    end
    chk_outs("dd_idle", 0, 1'b0, 1'b0, 1'b0, 1'b1);

    // LSB first, word 8'h0B -> 1,1,0,1,0,0,0,0.
    w = 8'hD0; valid_b = 1'b1; word_b = 8'h0B;
    step();
    for (int k = 1; k <= 8; k++) begin
      chk_outs($sformatf("lsb[%0d]", k), 1, 1'b1, w[8-k], k == 8, k == 8);
      if (k == 1) valid_b = 1'b0;
      step();
    end
    chk_outs("lsb_idle", 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // GAP=2, two words 8'hFF: 8 bits, 2 gap + 1 idle cycle, 8 bits.
    valid_c = 1'b1; word_c = 8'hFF;
    step();
    for (int k = 1; k <= 19; k++) begin
      if (k <= 8)
        chk_outs($sformatf("gap[%0d]", k), 2, 1'b1, 1'b1, k == 8, 1'b0);
      else if (k <= 10)
        chk_outs($sformatf("gap[%0d]", k), 2, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (k == 11)
        chk_outs($sformatf("gap[%0d]", k), 2, 1'b0, 1'b0, 1'b0, 1'b1);
      else
        chk_outs($sformatf("gap[%0d]", k), 2, 1'b1, 1'b1, k == 19, 1'b0);
      if (k == 12) valid_c = 1'b0;
      step();
    end
    chk_outs("gap_tail", 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during bit 4 of 8'hAA: outputs drop at once, nothing resumes.
    w = 8'hAA; valid_a = 1'b1; word_a = w;
    step();
    for (int k = 1; k <= 4; k++) begin
      chk_outs($sformatf("aa[%0d]", k), 0, 1'b1, w[8-k], 1'b0, 1'b0);
      if (k == 1) valid_a = 1'b0;
      if (k < 4) step();
    end
    #1 reset = 1'b1;
    #1 chk_outs("aa_rst", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_outs($sformatf("aa_post[%0d]", k), 0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // 8'h55 offered while shifting 8'h81 must never be taken.
    w = 8'h81; valid_a = 1'b1; word_a = w;
    step();
    for (int k = 1; k <= 8; k++) begin
      chk_outs($sformatf("drop[%0d]", k), 0, 1'b1, w[8-k], k == 8, k == 8);
      if (k == 1) valid_a = 1'b0;
      if (k == 3) begin valid_a = 1'b1; word_a = 8'h55; end
      if (k == 4) valid_a = 1'b0;
      step();
    end
    for (int k = 1; k <= 3; k++) begin
      chk_outs($sformatf("drop_idle[%0d]", k), 0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_bit_serializer.md
# piso_bit_serializer

Parallel-in/serial-out stage that feeds the 1101 sequence-detector family. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `o_data`. Each driven bit is qualified by `o_bit_valid`, and `o_last` marks the final bit of each word. An optional inter-word gap inserts idle cycles so the downstream detector sees framed or continuous streams as configured.

## Interface
Parameters:
- `WIDTH`, default 8: word width; legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `GAP`, default 0: idle cycles inserted after each word; legal range 0..15.

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `reset`, in, 1: asynchronous, active-high.
- `i_valid`, in, 1: upstream word available.
- `i_word`, in, WIDTH: word to serialize; sampled only on handshake.
- `o_ready`, out, 1: block can accept a word this cycle.
- `o_data`, out, 1: serial bit; drives the detector's `i_data`.
- `o_bit_valid`, out, 1: `o_data` carries a real bit this cycle.
- `o_last`, out, 1: current bit is the final bit of the word.

## Operation
- Three-state FSM: `IDLE`, `SHIFT`, `GAP`.
- Handshake: a word is accepted on a rising edge where `i_valid && o_ready`. Only the accepted word is captured into the shift register; `i_word` is ignored otherwise.
- `o_ready` behaviour:
  - 1 in `IDLE`.
  - 1 in `SHIFT` during the last-bit cycle only when `GAP==0`.
  - 0 otherwise, including all of `GAP`.
- `IDLE`: `o_bit_valid=0`, `o_data=0`, `o_last=0`. On accept → `SHIFT`, bit counter = 0.
- `SHIFT`:
  - `o_data` = current head bit of the shift register, per `MSB_FIRST`.
  - `o_bit_valid=1`.
  - Counter increments each cycle; `o_last=1` when counter == WIDTH-1.
  - On the last bit:
    - `GAP>0` → `GAP`, gap counter = GAP-1.
    - `GAP==0` with accept → stay in `SHIFT`, reload, counter = 0.
    - `GAP==0` without accept → `IDLE`.
- `GAP`:
  - Outputs as in `IDLE`, with `o_ready=0`.
  - Gap counter decrements; → `IDLE` when it reaches 0.
  - Total idle cycles = GAP, then `IDLE` adds at least one further cycle before the next word's first bit.
- `i_valid` may drop without an accept; no word is lost or duplicated.
- Counter width is `$clog2(WIDTH)`. The counter never wraps past WIDTH-1.

## Timing
- Reset: state = `IDLE`, shift register = 0, counters = 0.
  - `o_ready=1`, `o_data=0`, `o_bit_valid=0`, `o_last=0` immediately on assertion.
- Latency: the first bit appears the cycle after the accepting edge. Bit k appears k+1 cycles after accept.
- Throughput:
  - `GAP==0` with `i_valid` held: 100% bit occupancy, no bubble between words.
  - `GAP>0`: one word per WIDTH+GAP+1 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs, except that `o_ready` does not depend on `i_valid`.
- Reset mid-word: the word in flight is discarded, all outputs return to reset values asynchronously, and no partial `o_last` is emitted.

## Structure
- Shared package `seqdet_pkg`:
  - `ser_state_t` enum `{IDLE, SHIFT, GAP}`.
  - Shared localparams for default width and gap.
  - The detector's state typedefs also live there.
- Single module. No sub-module: the shift register and two counters are small enough to stay inline.

## Test plan
- WIDTH=8, MSB_FIRST=1, GAP=0; single word 8'hD0 → `o_data` 1,1,0,1,0,0,0,0 on cycles 1..8 after accept. `o_last` on cycle 8 only. Chained detector fires once.
- Back-to-back 8'hDD, 8'hDD with `i_valid` held → 16 consecutive `o_bit_valid` cycles with pattern 11011101 twice. `o_ready` is high on cycles 8 and 16.
- MSB_FIRST=0, word 8'h0B → `o_data` 1,1,0,1,0,0,0,0.
- GAP=2, two words 8'hFF → 8 valid bits, then `o_bit_valid=0` for 2 GAP cycles plus 1 IDLE cycle, then 8 valid bits. `o_ready=0` throughout GAP.
- Reset asserted during bit 4 of 8'hAA → all outputs to reset values within the same cycle. After release, `o_ready=1` and no residual bits are emitted.
- `i_valid` pulsed with 8'h55 while in `SHIFT` (`o_ready=0`), then dropped → word not accepted and never appears on `o_data`.
